store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of pending store entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 st_valid  input  1  memory-stage store request.
REQ-005 st_addr  input  32  store byte address, passed through unmodified.
REQ-006 st_data  input  32  store data, passed through unmodified.
REQ-007 st_op  input  3  store width: 000 word, 001 byte, 010 half; other codes rejected.
REQ-008 st_pc  input  32  PC of the store instruction, carried for write logging.
REQ-009 st_ready  output  1  buffer can accept a store this cycle.
REQ-010 ld_valid  input  1  a load is reading data memory this cycle.
REQ-011 ld_addr  input  32  load byte address.
REQ-012 ld_conflict  output  1  load must stall because a pending store hits its word.
REQ-013 dm_busy  input  1  data memory cannot take a write this cycle.
REQ-014 dm_we  output  1  write strobe to data memory.
REQ-015 dm_addr, dm_wdata, dm_pc  output  32 each  head-entry address, data and PC.
REQ-016 dm_op  output  3  head-entry width code.
REQ-017 count  output  log2(DEPTH)+1  number of valid entries.
REQ-018 empty  output  1  count == 0.

Function
REQ-019 Storage is a circular FIFO of DEPTH entries {addr, data, op, pc}, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-020 st_ready = (count != DEPTH); this is combinational from registered count only and is independent of a same-cycle dequeue.
REQ-021 Enqueue when st_valid && st_ready && st_op in {000,001,010}: the entry is written at tail and tail increments at the clock edge.
REQ-022 st_valid with an illegal st_op: no enqueue, no state change; st_ready is unaffected.
REQ-023 dm_we = !empty && !dm_busy, combinational; dm_addr/dm_wdata/dm_op/dm_pc always present the head entry, or zero when empty.
REQ-024 Dequeue when dm_we = 1: head increments at the same edge on which memory captures the write; latency from enqueue to dm_we is at least 1 cycle.
REQ-025 Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance.
REQ-026 Full (count == DEPTH) with a same-cycle dequeue: the store is still refused, because st_ready is already 0.
REQ-027 Empty with a same-cycle enqueue: no bypass; the entry drives dm_we from the next cycle.
REQ-028 ld_conflict = ld_valid && (some valid entry has addr[31:2] == ld_addr[31:2]), combinational.
REQ-029 ld_conflict excludes the entry being dequeued this cycle, and excludes a store being enqueued this cycle.
REQ-030 Valid-entry tracking is per entry (valid bit or pointer-range compare) and must stay correct across pointer wrap.
REQ-031 Stores drain in strict program order; entries are never merged or reordered.
REQ-032 dm_busy held high: the buffer retains every entry; stores are accepted until full, then st_ready = 0.

Reset
REQ-033 reset low asynchronously clears head, tail, count and all valid bits; entry payloads need not clear.
REQ-034 During reset and immediately after it: st_ready = 1, dm_we = 0, dm_addr/dm_wdata/dm_pc = 0, dm_op = 000, count = 0, empty = 1, ld_conflict = 0.
REQ-035 Reset asserted mid-operation discards all pending stores; no partial write is issued after reset releases.
REQ-036 A store presented in the first clock edge after reset release is accepted normally.

Verification
REQ-037 Single store: st_op=000, addr=0x10, data=0x12345678 with dm_busy=0 -> next cycle dm_we=1, dm_addr=0x10, dm_wdata=0x12345678; cycle after that empty=1.
REQ-038 Fill: dm_busy=1, five stores at addr 0x0,0x4,0x8,0xC,0x10 -> first four accepted, count=4, st_ready=0, fifth refused; then dm_busy=0 -> writes drain in order 0x0..0xC over 4 cycles.
REQ-039 Conflict: pending byte store at 0x21 (dm_busy=1), ld_valid with ld_addr=0x22 -> ld_conflict=1; ld_addr=0x24 -> ld_conflict=0.
REQ-040 Wrap: 10 back-to-back stores with enqueue and dequeue in the same cycles -> count stays 1, pointers wrap, dm_addr sequence matches input order, no loss or duplication.
REQ-041 Reset mid-drain: 3 pending entries, reset low for 1 cycle -> count=0, dm_we=0, no further writes issued.
REQ-042 Illegal op: st_op=011 with st_valid=1 -> count unchanged, and no dm_we in any following cycle.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between the memory stage and data memory.
// Stores are queued in a circular FIFO and drained one per cycle whenever the
// memory is not busy. Loads that touch the word of a pending store are flagged
// so the pipeline can stall them.
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,

   input  logic                     st_valid,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic [2:0]               st_op,
   input  logic [31:0]              st_pc,
   output logic                     st_ready,

   input  logic                     ld_valid,
   input  logic [31:0]              ld_addr,
   output logic                     ld_conflict,

   input  logic                     dm_busy,
   output logic                     dm_we,
   output logic [31:0]              dm_addr,
   output logic [31:0]              dm_wdata,
   output logic [2:0]               dm_op,
   output logic [31:0]              dm_pc,

   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [2:0] OP_WORD = 3'b000;
   localparam logic [2:0] OP_BYTE = 3'b001;
   localparam logic [2:0] OP_HALF = 3'b010;

   // Entry storage; payloads carry no reset, only valid bits do.
   logic [31:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [2:0]       op_q   [DEPTH];
   logic [31:0]      pc_q   [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;

   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   logic             op_legal_c;
   logic             enq_c;
   logic             deq_c;
   logic             empty_c;
   logic             hit_c;

   // Low address bits are irrelevant to word-granular conflict detection.
   logic             unused_ld_lsb;
   assign unused_ld_lsb = ^ld_addr[1:0];

   // Handshake and dequeue decisions, all from registered state.
   always_comb begin
      op_legal_c = (st_op == OP_WORD) || (st_op == OP_BYTE) || (st_op == OP_HALF);
      empty_c    = (count_q == CW'(0));
      st_ready   = (count_q != CW'(DEPTH));
      enq_c      = st_valid && st_ready && op_legal_c;
      dm_we      = !empty_c && !dm_busy;
      deq_c      = dm_we;
      empty      = empty_c;
      count      = count_q;
   end

   // Head entry presented to memory, zeroed when nothing is pending.
   always_comb begin
      dm_addr  = 32'd0;
      dm_wdata = 32'd0;
      dm_op    = 3'b000;
      dm_pc    = 32'd0;
      if (!empty_c) begin
         dm_addr  = addr_q[head_q];
         dm_wdata = data_q[head_q];
         dm_op    = op_q[head_q];
         dm_pc    = pc_q[head_q];
      end
   end

   // Word-match against pending entries, skipping the one leaving this cycle.
   always_comb begin
      hit_c = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2]) &&
             !(deq_c && (head_q == AW'(i)))) begin
            hit_c = 1'b1;
         end
      end
      ld_conflict = ld_valid && hit_c;
   end

   // Next-state for pointers, occupancy and per-entry valid bits.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (deq_c) begin
         head_d          = head_q + AW'(1);
         valid_d[head_q] = 1'b0;
      end
      if (enq_c) begin
         tail_d          = tail_q + AW'(1);
         valid_d[tail_q] = 1'b1;
      end
      unique case ({enq_c, deq_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards every pending store.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Payload capture at the tail slot on an accepted store.
   always_ff @(posedge clk) begin
      if (enq_c) begin
         addr_q[tail_q] <= st_addr;
         data_q[tail_q] <= st_data;
         op_q[tail_q]   <= st_op;
         pc_q[tail_q]   <= st_pc;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a reference queue tracks accepted stores and is
// compared against the head entry, occupancy and conflict flag every cycle.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  op;
      logic [31:0] pc;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          st_valid;
   logic [31:0]   st_addr;
   logic [31:0]   st_data;
   logic [2:0]    st_op;
   logic [31:0]   st_pc;
   logic          st_ready;
   logic          ld_valid;
   logic [31:0]   ld_addr;
   logic          ld_conflict;
   logic          dm_busy;
   logic          dm_we;
   logic [31:0]   dm_addr;
   logic [31:0]   dm_wdata;
   logic [2:0]    dm_op;
   logic [31:0]   dm_pc;
   logic [CW-1:0] count;
   logic          empty;

   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t mq[$];
   logic [31:0] pc_ctr = 32'h0000_1000;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .st_valid    (st_valid),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .st_op       (st_op),
      .st_pc       (st_pc),
      .st_ready    (st_ready),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_conflict (ld_conflict),
      .dm_busy     (dm_busy),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_op       (dm_op),
      .dm_pc       (dm_pc),
      .count       (count),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Compare all outputs to the model at the falling edge, then advance the
   // model by what the coming rising edge must do.
   task automatic tick();
      bit   deq;
      bit   acc;
      bit   hit;
      bit   legal;
      ent_t e;
      @(negedge clk);
      legal = (st_op == 3'b000) || (st_op == 3'b001) || (st_op == 3'b010);
      deq   = reset && (mq.size() != 0) && !dm_busy;
      acc   = reset && st_valid && (mq.size() != int'(DEPTH)) && legal;
      check("st_ready", 32'(st_ready), 32'(mq.size() != int'(DEPTH)));
      check("count",    32'(count),    32'(mq.size()));
      check("empty",    32'(empty),    32'(mq.size() == 0));
      check("dm_we",    32'(dm_we),    32'(deq));
      if (mq.size() != 0) begin
         check("dm_addr",  dm_addr,        mq[0].addr);
         check("dm_wdata", dm_wdata,       mq[0].data);
         check("dm_op",    32'(dm_op),     32'(mq[0].op));
         check("dm_pc",    dm_pc,          mq[0].pc);
      end else begin
         check("dm_addr_zero",  dm_addr,    32'd0);
         check("dm_wdata_zero", dm_wdata,   32'd0);
         check("dm_op_zero",    32'(dm_op), 32'd0);
         check("dm_pc_zero",    dm_pc,      32'd0);
      end
      hit = 1'b0;
      foreach (mq[i]) begin
         if (!(deq && i == 0) && (mq[i].addr[31:2] == ld_addr[31:2])) hit = 1'b1;
      end
      check("ld_conflict", 32'(ld_conflict), 32'(ld_valid && hit));
      if (deq) void'(mq.pop_front());
      if (acc) begin
         e.addr = st_addr;
         e.data = st_data;
         e.op   = st_op;
         e.pc   = st_pc;
         mq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_op    = op;
      st_pc    = pc_ctr;
      pc_ctr   = pc_ctr + 32'd4;
   endtask

   task automatic idle_store();
      st_valid = 1'b0;
      st_addr  = 32'hDEAD_BEEF;
      st_data  = 32'hCAFE_F00D;
      st_op    = 3'b000;
      st_pc    = 32'd0;
   endtask

   initial begin
      reset    = 1'b0;
      ld_valid = 1'b0;
      ld_addr  = 32'd0;
      dm_busy  = 1'b0;
      idle_store();

      // Held in reset: idle output values, stores ignored.
      tick();
      drive_store(32'h40, 32'h1, 3'b000);
      tick();
      idle_store();
      reset = 1'b1;

      // Store on the first edge after release, then observe it drain.
      drive_store(32'h10, 32'h1234_5678, 3'b000);
      tick();
      idle_store();
      check("single_we", 32'(dm_we), 32'd1);
      check("single_addr", dm_addr, 32'h10);
      check("single_data", dm_wdata, 32'h1234_5678);
      tick();
      check("single_empty", 32'(empty), 32'd1);
      tick();

      // Fill while memory is busy; the fifth store must be refused.
      dm_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_store(32'(i * 4), 32'hA000_0000 + 32'(i), 3'b000);
         tick();
      end
      idle_store();
      check("fill_count", 32'(count), 32'd4);
      check("fill_ready", 32'(st_ready), 32'd0);
      tick();
      dm_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("drain_order", dm_addr, 32'(i * 4));
         tick();
      end
      tick();

      // Full with a same-cycle dequeue still refuses the store.
      dm_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_store(32'h100 + 32'(i * 4), 32'(i), 3'b010);
         tick();
      end
      dm_busy = 1'b0;
      drive_store(32'h200, 32'h55, 3'b000);
      tick();
      idle_store();
      repeat (5) tick();

      // Word-granular load conflict detection.
      dm_busy = 1'b1;
      drive_store(32'h21, 32'hFF, 3'b001);
      tick();
      idle_store();
      ld_valid = 1'b1;
      ld_addr  = 32'h22;
      tick();
      ld_addr  = 32'h24;
      tick();
      ld_addr  = 32'h22;
      dm_busy  = 1'b0;
      tick();
      drive_store(32'h30, 32'h77, 3'b000);
      ld_addr  = 32'h30;
      tick();
      idle_store();
      tick();
      ld_valid = 1'b0;
      tick();

      // Back-to-back enqueue and dequeue across pointer wrap.
      drive_store(32'h300, 32'h0, 3'b000);
      tick();
      for (int i = 1; i <= 10; i++) begin
         drive_store(32'h300 + 32'(i * 4), 32'(i), 3'b000);
         tick();
         check("wrap_count", 32'(count), 32'd1);
      end
      idle_store();
      repeat (2) tick();

      // Illegal width codes are ignored entirely.
      for (int i = 3; i < 8; i++) begin
         drive_store(32'h400, 32'h9, 3'(i));
         tick();
      end
      idle_store();
      repeat (2) tick();

      // Reset mid-drain discards pending stores.
      dm_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_store(32'h500 + 32'(i * 4), 32'(i), 3'b000);
         tick();
      end
      idle_store();
      dm_busy = 1'b0;
      reset   = 1'b0;
      #1;
      check("rst_async_count", 32'(count), 32'd0);
      check("rst_async_we", 32'(dm_we), 32'd0);
      mq.delete();
      tick();
      reset = 1'b1;
      repeat (4) tick();

      // Randomised traffic against the model.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            drive_store(32'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 4)));
         end else begin
            idle_store();
         end
         dm_busy  = ($urandom_range(0, 2) == 0);
         ld_valid = $urandom_range(0, 1) == 1;
         ld_addr  = 32'($urandom_range(0, 63));
         tick();
      end
      idle_store();
      dm_busy  = 1'b0;
      ld_valid = 1'b0;
      repeat (6) tick();
      check("final_empty", 32'(empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
